// File: rtl/local_pattern_table.sv
// Local pattern table: 2^HIST_W saturating counters indexed by local history.
// Registered lookup with write-first bypass from a same-cycle update.
module local_pattern_table #(
    parameter int unsigned HIST_W   = 10,
    parameter int unsigned CTR_W    = 2,
    parameter int unsigned INIT_CTR = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lookup_v_i,
    input  logic [HIST_W-1:0] hist_i,
    input  logic              update_v_i,
    input  logic [HIST_W-1:0] update_hist_i,
    input  logic              update_taken_i,
    output logic              ready_o,
    output logic              pred_v_o,
    output logic              pred_taken_o,
    output logic [CTR_W-1:0]  pred_ctr_o
);

    localparam int unsigned DEPTH = 1 << HIST_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [HIST_W-1:0]  r_sweep;
    logic [CTR_W-1:0]   r_table [DEPTH];
    logic               r_pred_v;
    logic [CTR_W-1:0]   r_pred_ctr;

    logic               w_ready;
    logic               w_lk_acc;
    logic               w_upd_acc;
    logic [CTR_W-1:0]   w_upd_old;
    logic [CTR_W-1:0]   w_upd_new;
    logic [CTR_W-1:0]   w_lk_val;

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_sweep == '1) w_state_nxt = ST_READY;
    end

    assign w_ready   = (r_state == ST_READY);
    assign w_lk_acc  = lookup_v_i & w_ready;
    assign w_upd_acc = update_v_i & w_ready;

    always_comb begin
        w_upd_old = r_table[update_hist_i];
        w_upd_new = w_upd_old;
        if (update_taken_i) begin
            if (w_upd_old != CTR_MAX) w_upd_new = w_upd_old + 1'b1;
        end else begin
            if (w_upd_old != '0) w_upd_new = w_upd_old - 1'b1;
        end
    end

    // Same-index update in this cycle forwards its new value to the lookup.
    always_comb begin
        w_lk_val = r_table[hist_i];
        if (w_upd_acc && update_hist_i == hist_i) w_lk_val = w_upd_new;
    end

    always_ff @(posedge clock) begin
        if (reset) r_sweep <= '0;
        else if (r_state == ST_INIT) r_sweep <= r_sweep + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == ST_INIT) r_table[r_sweep] <= CTR_INIT;
            else if (w_upd_acc)     r_table[update_hist_i] <= w_upd_new;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pred_v   <= 1'b0;
            r_pred_ctr <= '0;
        end else begin
            r_pred_v <= w_lk_acc;
            if (w_lk_acc) r_pred_ctr <= w_lk_val;
        end
    end

    assign ready_o      = w_ready;
    assign pred_v_o     = r_pred_v;
    assign pred_ctr_o   = r_pred_ctr;
    assign pred_taken_o = r_pred_ctr[CTR_W-1];

endmodule

// File: tb/tb_local_pattern_table.sv
// Scoreboard bench for local_pattern_table: driver pushes expected predictions
// from an array model, an independent monitor checks outputs on the falling edge.
module tb_local_pattern_table;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       lookup_v_i = 1'b0;
    logic [9:0] hist_i = '0;
    logic       update_v_i = 1'b0;
    logic [9:0] update_hist_i = '0;
    logic       update_taken_i = 1'b0;
    logic       ready_o;
    logic       pred_v_o;
    logic       pred_taken_o;
    logic [1:0] pred_ctr_o;

    local_pattern_table #(.HIST_W(10), .CTR_W(2), .INIT_CTR(1)) dut (
        .clock(clock),
        .reset(reset),
        .lookup_v_i(lookup_v_i),
        .hist_i(hist_i),
        .update_v_i(update_v_i),
        .update_hist_i(update_hist_i),
        .update_taken_i(update_taken_i),
        .ready_o(ready_o),
        .pred_v_o(pred_v_o),
        .pred_taken_o(pred_taken_o),
        .pred_ctr_o(pred_ctr_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned due;
        int          ctr;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    int          m_tab [1024];
    bit          m_ready = 1'b0;
    int          m_cnt = 0;
    int          m_last = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor
    always @(negedge clock) begin
        tests++;
        if (ready_o !== m_ready) begin
            fails++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready_o, m_ready);
        end
        if (pred_v_o === 1'b1) begin
            tests++;
            if (q.size() > 0 && q[0].due == cyc) begin
                if (pred_ctr_o !== q[0].ctr[1:0] || pred_taken_o !== (q[0].ctr >= 2)) begin
                    fails++;
                    $display("FAIL pred cyc=%0d got ctr=%0d taken=%b exp ctr=%0d taken=%b",
                             cyc, pred_ctr_o, pred_taken_o, q[0].ctr, q[0].ctr >= 2);
                end
                m_last = q[0].ctr;
                void'(q.pop_front());
            end else begin
                fails++;
                $display("FAIL unexpected_pred cyc=%0d got pred_v=1 exp pred_v=0", cyc);
            end
        end else begin
            tests++;
            if (q.size() > 0 && q[0].due == cyc) begin
                fails++;
                $display("FAIL missing_pred cyc=%0d got pred_v=%b exp pred_v=1", cyc, pred_v_o);
                void'(q.pop_front());
            end else if (pred_ctr_o !== m_last[1:0] || pred_taken_o !== (m_last >= 2)) begin
                fails++;
                $display("FAIL hold cyc=%0d got ctr=%0d taken=%b exp ctr=%0d",
                         cyc, pred_ctr_o, pred_taken_o, m_last);
            end
        end
    end

    task automatic step(input bit rst, input bit lk, input int lh,
                        input bit up, input int uh, input bit ut);
        exp_t e;
        reset          = rst;
        lookup_v_i     = lk;
        hist_i         = lh[9:0];
        update_v_i     = up;
        update_hist_i  = uh[9:0];
        update_taken_i = ut;
        if (!rst && m_ready) begin
            if (up) begin
                if (ut && m_tab[uh] < 3) m_tab[uh] = m_tab[uh] + 1;
                else if (!ut && m_tab[uh] > 0) m_tab[uh] = m_tab[uh] - 1;
            end
            if (lk) begin
                e.due = cyc + 1;
                e.ctr = m_tab[lh];
                q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            m_last  = 0;
            foreach (m_tab[i]) m_tab[i] = 1;
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == 1024) m_ready = 1'b1;
        end
    endtask

    task automatic wait_init(input bit hold_req, input int h);
        int n = 0;
        while (!m_ready && n < 2000) begin
            step(0, hold_req, h, hold_req, h, 1);
            n++;
        end
        if (ready_o !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL init_timeout got ready=%b exp ready=1", ready_o);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        step(1, 1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1, 1);
        // Requests held during the sweep must be dropped
        wait_init(1, 1);
        idle();
        step(0, 1, 'h3FF, 0, 0, 0);
        step(0, 1, 'h001, 0, 0, 0);
        idle();

        // Saturation up then down
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 'h155, 1);
            step(0, 1, 'h155, 0, 0, 0);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 'h155, 0);
            step(0, 1, 'h155, 0, 0, 0);
        end

        // Collision bypass, then neighbour
        step(0, 1, 'h0AA, 1, 'h0AA, 1);
        step(0, 1, 'h0AB, 0, 0, 0);
        idle();

        // Back-to-back updates to one index with same-cycle lookups
        step(0, 1, 'h020, 1, 'h020, 1);
        step(0, 1, 'h020, 1, 'h020, 1);
        step(0, 1, 'h020, 1, 'h020, 0);
        step(0, 1, 'h020, 1, 'h020, 0);
        step(0, 1, 'h020, 1, 'h020, 0);

        // Streaming over 0..15 with random interleaved updates
        for (int i = 0; i < 400; i++)
            step(0, 1, i % 16, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
        idle();

        // Reset while a lookup is issued
        step(0, 0, 0, 1, 'h010, 1);
        step(0, 0, 0, 1, 'h010, 1);
        step(0, 1, 'h010, 1, 'h010, 1);
        step(1, 1, 'h010, 0, 0, 0);
        wait_init(0, 0);
        step(0, 1, 'h010, 0, 0, 0);
        idle();
        idle();

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
